// File: rtl/icache_refill_engine.sv
// I-cache line refill engine: pipelined word reads (up to MAX_OUTSTANDING in flight),
// line assembly and single-cycle commit. Define ICACHE_REFILL_CWF_EN for critical-word-first.
module icache_refill_engine #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned LINE_WORDS      = 8,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     miss_req,
    input  logic [ADDR_W-1:0]        miss_addr,
    output logic                     busy,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [31:0]              mem_rdata,
    output logic                     line_we,
    output logic [ADDR_W-1:0]        line_addr,
    output logic [LINE_WORDS*32-1:0] line_data,
    output logic                     refill_done,
    output logic                     cpu_word_valid,
    output logic [31:0]              cpu_word,
    output logic                     protocol_err
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned IDX_W  = OFF_W + 1;
    localparam int unsigned BASE_W = ADDR_W - OFF_W - 2;

    typedef enum logic [1:0] {StIdle, StFill, StCommit} state_e;

    state_e                  state_q, state_d;
    logic [BASE_W-1:0]       line_base_q, line_base_d;
    logic [OFF_W-1:0]        crit_q, crit_d;
    logic [IDX_W-1:0]        addr_cnt_q, addr_cnt_d;
    logic [IDX_W-1:0]        data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0]        outst_q, outst_d;
    logic [LINE_WORDS*32-1:0] line_data_q, line_data_d;
    logic                    err_q, err_d;

    logic             accept;
    logic             beat;
    logic [OFF_W-1:0] req_idx;
    logic [OFF_W-1:0] wr_idx;

    logic unused_miss_addr;
    assign unused_miss_addr = ^miss_addr[1:0];

`ifdef ICACHE_REFILL_CWF_EN
    assign req_idx = crit_q + addr_cnt_q[OFF_W-1:0];
    assign wr_idx  = crit_q + data_cnt_q[OFF_W-1:0];
`else
    assign req_idx = addr_cnt_q[OFF_W-1:0];
    assign wr_idx  = data_cnt_q[OFF_W-1:0];
`endif

    assign mem_req = (state_q == StFill) && (addr_cnt_q < IDX_W'(LINE_WORDS)) &&
                     (outst_q < CNT_W'(MAX_OUTSTANDING));
    assign mem_addr = {line_base_q, req_idx, 2'b00};
    assign accept   = mem_req && mem_addr_ok;
    // A beat only counts against a request that is actually in flight.
    assign beat     = (state_q == StFill) && mem_data_ok && (outst_q != '0);

    assign busy         = (state_q != StIdle);
    assign line_we      = (state_q == StCommit);
    assign refill_done  = (state_q == StCommit);
    assign line_addr    = {line_base_q, {(OFF_W + 2){1'b0}}};
    assign line_data    = line_data_q;
    assign protocol_err = err_q;

    always_comb begin
        state_d     = state_q;
        line_base_d = line_base_q;
        crit_d      = crit_q;
        addr_cnt_d  = addr_cnt_q;
        data_cnt_d  = data_cnt_q;
        outst_d     = outst_q;
        line_data_d = line_data_q;
        err_d       = err_q;

        if (mem_data_ok && (outst_q == '0)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (miss_req) begin
                    line_base_d = miss_addr[ADDR_W-1:OFF_W+2];
                    crit_d      = miss_addr[OFF_W+1:2];
                    addr_cnt_d  = '0;
                    data_cnt_d  = '0;
                    outst_d     = '0;
                    state_d     = StFill;
                end
            end
            StFill: begin
                if (accept) begin
                    addr_cnt_d = addr_cnt_q + IDX_W'(1);
                end
                if (beat) begin
                    data_cnt_d = data_cnt_q + IDX_W'(1);
                    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                        if (wr_idx == OFF_W'(i)) begin
                            line_data_d[i*32 +: 32] = mem_rdata;
                        end
                    end
                end
                unique case ({accept, beat})
                    2'b10:   outst_d = outst_q + CNT_W'(1);
                    2'b01:   outst_d = outst_q - CNT_W'(1);
                    default: outst_d = outst_q;
                endcase
                // Look at the next count so the commit lands one cycle after the last beat.
                if (data_cnt_d == IDX_W'(LINE_WORDS)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            line_base_q <= '0;
            crit_q      <= '0;
            addr_cnt_q  <= '0;
            data_cnt_q  <= '0;
            outst_q     <= '0;
            line_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_base_q <= line_base_d;
            crit_q      <= crit_d;
            addr_cnt_q  <= addr_cnt_d;
            data_cnt_q  <= data_cnt_d;
            outst_q     <= outst_d;
            line_data_q <= line_data_d;
            err_q       <= err_d;
        end
    end

`ifdef ICACHE_REFILL_CWF_EN
    // Early restart: forward the first returned beat (the critical word) straight to the core.
    logic        cpu_valid_q, cpu_valid_d;
    logic [31:0] cpu_word_q, cpu_word_d;

    always_comb begin
        cpu_valid_d = beat && (data_cnt_q == '0);
        cpu_word_d  = cpu_word_q;
        if (cpu_valid_d) begin
            cpu_word_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_valid_q <= 1'b0;
            cpu_word_q  <= '0;
        end else begin
            cpu_valid_q <= cpu_valid_d;
            cpu_word_q  <= cpu_word_d;
        end
    end

    assign cpu_word_valid = cpu_valid_q;
    assign cpu_word       = cpu_word_q;
`else
    logic [31:0] cpu_word_sel;

    always_comb begin
        cpu_word_sel = '0;
        for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            if (crit_q == OFF_W'(i)) begin
                cpu_word_sel = line_data_q[i*32 +: 32];
            end
        end
    end

    assign cpu_word_valid = (state_q == StCommit);
    assign cpu_word       = cpu_word_sel;
`endif

endmodule
